noc_control_module_dii_arbiter: RTL
===================================

// Module: noc_control_module_dii_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter sharing the single debug (DII) event output of
//  the NoC control module between its event sources: utilization collector, fault
//  reporter, config acknowledger, ... A grant is held for a whole debug packet,
//  released on 'last'. Packet length is guarded against MAX_DI_PKT_LEN; overlong
//  packets are truncated and drained.
// PARAMETERS
//  NUM_PORTS       2   number of requesting event sources (2..8)
//  MAX_DI_PKT_LEN  12  max flits per debug packet incl. DEST/SRC/FLAGS header (>=4)
// PORTS
//  clk            in   1             single clock
//  rst_debug      in   1             asynchronous, active-high reset
//  in_flit        in   NUM_PORTS x dii_flit (18b: data[15:0], valid, last) sources
//  in_ready       out  NUM_PORTS     per-source ready
//  out_flit       out  dii_flit      merged stream toward debug ring
//  out_ready      in   1             downstream ready
//  grant          out  NUM_PORTS     one-hot current owner (0 when idle)
//  err_len        out  NUM_PORTS     sticky: source sent packet > MAX_DI_PKT_LEN
//  err_clr        in   1             clears all err_len bits (wins over new set: no)
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr pointer=NUM_PORTS-1, flit_cnt=0, err_len=0;
//    out_flit.valid=0, out_flit.last=0, out_flit.data=0, in_ready=0.
//  - States: IDLE, XFER, DRAIN.
//  - IDLE: out valid=0, all in_ready=0. If any in_flit[i].valid: pick first valid i
//    searching rr+1, rr+2, ... (wrapping mod NUM_PORTS); register grant=1<<i, rr=i,
//    flit_cnt=0 -> XFER. Arbitration costs exactly one cycle; first flit appears on
//    out_flit the cycle after the request is seen.
//  - XFER: out_flit = in_flit[g] combinationally; in_ready[g]=out_ready, other
//    in_ready=0. Transfer when valid & out_ready: flit_cnt++ (saturating 4b..8b wide
//    enough for MAX_DI_PKT_LEN).
//    * transfer with in last=1 -> grant=0 -> IDLE.
//    * transfer number MAX_DI_PKT_LEN (flit_cnt==MAX_DI_PKT_LEN-1) with last=0:
//      out_flit.last forced 1, err_len[g] set -> DRAIN (grant kept).
//  - DRAIN: out valid=0; in_ready[g]=1; source flits discarded; on accepted flit
//    with last=1 -> grant=0 -> IDLE. Other sources wait.
//  - Never changes grant mid-packet; valid from non-granted ports ignored, no flit
//    lost or duplicated. Source may drop valid mid-packet; grant holds (no timeout).
//  - Fairness: source granted last is lowest priority next round; with all ports
//    requesting continuously, grants rotate 0,1,..,N-1,0.
//  - err_clr: err_len <= 0 that cycle; a set in the same cycle is taken (set wins).
//  - Reset mid-packet: immediate return to IDLE, output valid deasserted
//    asynchronously; partial packet is the downstream's concern.
// TESTING
//  1 Reset: assert rst_debug mid-XFER -> out valid=0, grant=0, err_len=0 same cycle.
//  2 Single src0 5-flit packet, out_ready=1 -> flits out cycles 1..5, last on 5th,
//    grant=01 then 00; idle cycle before next packet.
//  3 Both srcs send continuous 4-flit packets -> output order src0,src1,src0,src1,
//    never interleaved within a packet; all 16 flits of 4 packets data-exact.
//  4 Backpressure: out_ready toggled 1/0 each cycle during 6-flit packet -> in_ready
//    mirrors out_ready, 6 flits out in order, no duplicates.
//  5 src1 sends 15 flits, last on 15th (MAX=12) -> 12 flits out, 12th has last=1,
//    err_len=10, flits 13-15 drained, then src0 served; err_clr -> err_len=00.
//  6 NUM_PORTS=3, src2 granted last, src0 and src2 request -> src0 granted next.

Source files
------------

// File: rtl/noc_control_module_dii_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_control_module_dii_arbiter
// Description : Packet-atomic round-robin arbiter merging debug event sources
//               onto the single DII event output, with length guarding.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_control_module_dii_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int MAX_DI_PKT_LEN = 12
) (
    input  logic                        clk,
    input  logic                        rst_debug,
    input  logic [NUM_PORTS-1:0][17:0]  in_flit,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [17:0]                 out_flit,
    input  logic                        out_ready,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [NUM_PORTS-1:0]        err_len,
    input  logic                        err_clr
);

    // Flit layout: {data[15:0], valid, last}
    localparam int c_valid_bit = 1;
    localparam int c_last_bit  = 0;
    localparam int c_idx_w     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_cnt_w     = $clog2(MAX_DI_PKT_LEN + 1);

    localparam logic [c_idx_w-1:0] c_rr_reset = c_idx_w'(NUM_PORTS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_DI_PKT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [NUM_PORTS-1:0] grant_q,   grant_d;
    logic [c_idx_w-1:0]   rr_q,      rr_d;
    logic [c_cnt_w-1:0]   flit_cnt_q, flit_cnt_d;
    logic [NUM_PORTS-1:0] err_len_q, err_len_d;

    logic [17:0]          w_cur_flit;
    logic                 w_cur_valid;
    logic                 w_cur_last;
    logic                 w_req_found;
    logic [c_idx_w-1:0]   w_req_idx;
    logic [c_idx_w-1:0]   w_cand;

    // While a grant is held, rr_q is the index of the owning source.
    assign w_cur_flit  = in_flit[rr_q];
    assign w_cur_valid = w_cur_flit[c_valid_bit];
    assign w_cur_last  = w_cur_flit[c_last_bit];

    // Round-robin search starting just after the most recently granted source.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = rr_q;
        w_cand      = rr_q;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = c_idx_w'((int'(rr_q) + k) % NUM_PORTS);
            if (!w_req_found && in_flit[w_cand][c_valid_bit]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        flit_cnt_d = flit_cnt_q;
        err_len_d  = err_clr ? '0 : err_len_q;
        out_flit   = '0;
        in_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_req_found) begin
                    grant_d            = '0;
                    grant_d[w_req_idx] = 1'b1;
                    rr_d               = w_req_idx;
                    flit_cnt_d         = '0;
                    state_d            = ST_XFER;
                end
            end

            ST_XFER: begin
                out_flit       = w_cur_flit;
                in_ready[rr_q] = out_ready;
                // The last permitted flit always closes the packet downstream.
                if (flit_cnt_q == c_cnt_last) begin
                    out_flit[c_last_bit] = 1'b1;
                end
                if (w_cur_valid && out_ready) begin
                    if (flit_cnt_q != c_cnt_sat) begin
                        flit_cnt_d = flit_cnt_q + 1'b1;
                    end
                    if (w_cur_last) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else if (flit_cnt_q == c_cnt_last) begin
                        err_len_d[rr_q] = 1'b1;
                        state_d         = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                in_ready[rr_q] = 1'b1;
                if (w_cur_valid && w_cur_last) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_debug) begin
        if (rst_debug) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_q       <= c_rr_reset;
            flit_cnt_q <= '0;
            err_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            flit_cnt_q <= flit_cnt_d;
            err_len_q  <= err_len_d;
        end
    end

    assign grant   = grant_q;
    assign err_len = err_len_q;

endmodule
`default_nettype wire
